// File: rtl/thor2022_regfetch.sv
// thor2022_regfetch: register-fetch stage.
// Holds the 64-entry general register file and a pending-write scoreboard,
// stalls decode on RAW/WAW hazards, forwards the single writeback result and
// presents registered operands to execute over a valid/ready handshake.
module thor2022_regfetch #(
  parameter int unsigned WID   = 64,
  parameter int unsigned NREGS = 64,
  parameter int unsigned CNTW  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dec_v,
  output logic            dec_rdy,
  input  logic [5:0]      dec_Ra,
  input  logic [5:0]      dec_Rb,
  input  logic [5:0]      dec_Rc,
  input  logic [5:0]      dec_Rt,
  input  logic            dec_rfwr,
  input  logic [63:0]     dec_ir,
  input  logic            wb_v,
  input  logic            wb_we,
  input  logic [5:0]      wb_Rt,
  input  logic [WID-1:0]  wb_res,
  input  logic            flush_i,
  output logic            out_v,
  input  logic            out_rdy,
  output logic [WID-1:0]  out_a,
  output logic [WID-1:0]  out_b,
  output logic [WID-1:0]  out_c,
  output logic [5:0]      out_Rt,
  output logic            out_rfwr,
  output logic [63:0]     out_ir,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int unsigned IW = 6;

  // Architectural state
  logic [WID-1:0]   rf_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  // Output register
  logic             out_v_q, out_v_d;
  logic [WID-1:0]   out_a_q, out_a_d;
  logic [WID-1:0]   out_b_q, out_b_d;
  logic [WID-1:0]   out_c_q, out_c_d;
  logic [IW-1:0]    out_rt_q, out_rt_d;
  logic             out_rfwr_q, out_rfwr_d;
  logic [63:0]      out_ir_q, out_ir_d;
  logic [CNTW-1:0]  stall_q, stall_d;

  // Combinational helpers
  logic             wb_wr_s;
  logic             haz_a_s, haz_b_s, haz_c_s, waw_s;
  logic             out_free_s;
  logic             rdy_s;
  logic             issue_s;
  logic [WID-1:0]   op_a_s, op_b_s, op_c_s;

  // A source is hazardous while its producer is pending, unless that very
  // producer is writing the file this cycle (then the value is forwarded).
  function automatic logic src_haz(input logic [IW-1:0] idx,
                                   input logic          pend_bit,
                                   input logic          wb_wr,
                                   input logic [IW-1:0] wb_rt);
    return pend_bit & (idx != 6'd0) & ~(wb_wr & (wb_rt == idx));
  endfunction

  // Operand read priority: r0, then writeback forward, then file value.
  function automatic logic [WID-1:0] op_sel(input logic [IW-1:0]  idx,
                                            input logic [WID-1:0] file_val,
                                            input logic           wb_wr,
                                            input logic [IW-1:0]  wb_rt,
                                            input logic [WID-1:0] wb_data);
    logic [WID-1:0] r;
    if (idx == 6'd0) begin
      r = {WID{1'b0}};
    end else if (wb_wr && (wb_rt == idx)) begin
      r = wb_data;
    end else begin
      r = file_val;
    end
    return r;
  endfunction

  // Hazard detection and ready generation
  always_comb begin
    wb_wr_s    = wb_v & wb_we;
    haz_a_s    = src_haz(dec_Ra, pend_q[dec_Ra], wb_wr_s, wb_Rt);
    haz_b_s    = src_haz(dec_Rb, pend_q[dec_Rb], wb_wr_s, wb_Rt);
    haz_c_s    = src_haz(dec_Rc, pend_q[dec_Rc], wb_wr_s, wb_Rt);
    // A WAW is cleared by any retirement of the same index, write or not.
    waw_s      = dec_rfwr & (dec_Rt != 6'd0) & pend_q[dec_Rt] &
                 ~(wb_v & (wb_Rt == dec_Rt));
    out_free_s = ~out_v_q | out_rdy | flush_i;
    rdy_s      = rst_ni & ~haz_a_s & ~haz_b_s & ~haz_c_s & ~waw_s & out_free_s;
    issue_s    = dec_v & rdy_s;
  end

  // Operand selection with writeback forwarding
  always_comb begin
    op_a_s = op_sel(dec_Ra, rf_q[dec_Ra], wb_wr_s, wb_Rt, wb_res);
    op_b_s = op_sel(dec_Rb, rf_q[dec_Rb], wb_wr_s, wb_Rt, wb_res);
    op_c_s = op_sel(dec_Rc, rf_q[dec_Rc], wb_wr_s, wb_Rt, wb_res);
  end

  // Scoreboard next state: retire clear, flush clear, then issue set (set wins)
  always_comb begin
    pend_d = pend_q;
    if (wb_v) begin
      pend_d[wb_Rt] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (flush_i && out_v_q && out_rfwr_q) begin
      pend_d[out_rt_q] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (issue_s && dec_rfwr && (dec_Rt != 6'd0)) begin
      pend_d[dec_Rt] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
    pend_d[0] = 1'b0;
  end

  // Output register next state: load on issue, drop on flush or accept, else hold
  always_comb begin
    out_v_d    = out_v_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_c_d    = out_c_q;
    out_rt_d   = out_rt_q;
    out_rfwr_d = out_rfwr_q;
    out_ir_d   = out_ir_q;
    if (issue_s) begin
      out_v_d    = 1'b1;
      out_a_d    = op_a_s;
      out_b_d    = op_b_s;
      out_c_d    = op_c_s;
      out_rt_d   = dec_Rt;
      out_rfwr_d = dec_rfwr;
      out_ir_d   = dec_ir;
    end else if (flush_i) begin
      out_v_d = 1'b0;
    end else if (out_v_q && out_rdy) begin
      out_v_d = 1'b0;
    end else begin
      out_v_d = out_v_q;
    end
  end

  // Saturating stall counter next state
  always_comb begin
    stall_d = stall_q;
    if (dec_v && !rdy_s && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // Register file write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wb_wr_s && (wb_Rt != 6'd0)) begin
      rf_q[wb_Rt] <= wb_res;
    end
  end

  // Pipeline state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q     <= {NREGS{1'b0}};
      out_v_q    <= 1'b0;
      out_a_q    <= {WID{1'b0}};
      out_b_q    <= {WID{1'b0}};
      out_c_q    <= {WID{1'b0}};
      out_rt_q   <= 6'd0;
      out_rfwr_q <= 1'b0;
      out_ir_q   <= 64'd0;
      stall_q    <= {CNTW{1'b0}};
    end else begin
      pend_q     <= pend_d;
      out_v_q    <= out_v_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_c_q    <= out_c_d;
      out_rt_q   <= out_rt_d;
      out_rfwr_q <= out_rfwr_d;
      out_ir_q   <= out_ir_d;
      stall_q    <= stall_d;
    end
  end

  assign dec_rdy   = rdy_s;
  assign out_v     = out_v_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_Rt    = out_rt_q;
  assign out_rfwr  = out_rfwr_q;
  assign out_ir    = out_ir_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_thor2022_regfetch.sv
// Bench for thor2022_regfetch: directed vector table, a hand-written reset
// sequence and a randomized run against a behavioural scoreboard model.
module tb_thor2022_regfetch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dec_v;
  logic        dec_rdy;
  logic [5:0]  dec_Ra, dec_Rb, dec_Rc, dec_Rt;
  logic        dec_rfwr;
  logic [63:0] dec_ir;
  logic        wb_v, wb_we;
  logic [5:0]  wb_Rt;
  logic [63:0] wb_res;
  logic        flush_i;
  logic        out_v;
  logic        out_rdy;
  logic [63:0] out_a, out_b, out_c;
  logic [5:0]  out_Rt;
  logic        out_rfwr;
  logic [63:0] out_ir;
  logic [31:0] stall_cnt;

  thor2022_regfetch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dec_v(dec_v), .dec_rdy(dec_rdy),
    .dec_Ra(dec_Ra), .dec_Rb(dec_Rb), .dec_Rc(dec_Rc), .dec_Rt(dec_Rt),
    .dec_rfwr(dec_rfwr), .dec_ir(dec_ir), .wb_v(wb_v), .wb_we(wb_we),
    .wb_Rt(wb_Rt), .wb_res(wb_res), .flush_i(flush_i), .out_v(out_v),
    .out_rdy(out_rdy), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_Rt(out_Rt), .out_rfwr(out_rfwr), .out_ir(out_ir),
    .stall_cnt(stall_cnt)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  logic rdy_seen;

  // Reference model state
  logic [63:0] m_rf [64];
  bit          m_pend [64];
  bit          m_ov, m_rfwr;
  logic [63:0] m_a, m_b, m_c, m_ir;
  logic [5:0]  m_rt;
  logic [31:0] m_st;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_haz(input logic [5:0] x);
    return m_pend[x] && (x != 6'd0) && !(wb_v && wb_we && wb_Rt == x);
  endfunction

  function automatic bit m_ready();
    bit waw;
    waw = dec_rfwr && (dec_Rt != 6'd0) && m_pend[dec_Rt] && !(wb_v && wb_Rt == dec_Rt);
    return rst_ni && !m_haz(dec_Ra) && !m_haz(dec_Rb) && !m_haz(dec_Rc) && !waw &&
           (!m_ov || out_rdy || flush_i);
  endfunction

  function automatic logic [63:0] m_read(input logic [5:0] x);
    if (x == 6'd0) return 64'd0;
    if (wb_v && wb_we && wb_Rt == x) return wb_res;
    return m_rf[x];
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic m_edge();
    bit iss;
    logic [63:0] a, b, c;
    iss = dec_v && m_ready();
    a = m_read(dec_Ra); b = m_read(dec_Rb); c = m_read(dec_Rc);
    if (wb_v && wb_we && wb_Rt != 6'd0) m_rf[wb_Rt] = wb_res;
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
      m_ov = 1'b0; m_a = 64'd0; m_b = 64'd0; m_c = 64'd0;
      m_rt = 6'd0; m_rfwr = 1'b0; m_ir = 64'd0; m_st = 32'd0;
    end else begin
      if (wb_v) m_pend[wb_Rt] = 1'b0;
      if (flush_i && m_ov && m_rfwr) m_pend[m_rt] = 1'b0;
      if (iss && dec_rfwr && dec_Rt != 6'd0) m_pend[dec_Rt] = 1'b1;
      if (dec_v && !iss && m_st != 32'hFFFF_FFFF) m_st = m_st + 32'd1;
      if (iss) begin
        m_ov = 1'b1; m_a = a; m_b = b; m_c = c;
        m_rt = dec_Rt; m_rfwr = dec_rfwr; m_ir = dec_ir;
      end else if (flush_i || (m_ov && out_rdy)) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // One clock: check ready mid-cycle, advance model, check registered outputs.
  task automatic step();
    @(negedge clk_i);
    rdy_seen = dec_rdy;
    chk("dec_rdy", {63'd0, dec_rdy}, {63'd0, m_ready()});
    @(posedge clk_i);
    m_edge();
    #1;
    chk("out_v",     {63'd0, out_v},    {63'd0, m_ov});
    chk("out_a",     out_a,             m_a);
    chk("out_b",     out_b,             m_b);
    chk("out_c",     out_c,             m_c);
    chk("out_Rt",    {58'd0, out_Rt},   {58'd0, m_rt});
    chk("out_rfwr",  {63'd0, out_rfwr}, {63'd0, m_rfwr});
    chk("out_ir",    out_ir,            m_ir);
    chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_st});
  endtask

  task automatic idle_inputs();
    dec_v = 1'b0; dec_Ra = 6'd0; dec_Rb = 6'd0; dec_Rc = 6'd0; dec_Rt = 6'd0;
    dec_rfwr = 1'b0; dec_ir = 64'd0; wb_v = 1'b0; wb_we = 1'b0; wb_Rt = 6'd0;
    wb_res = 64'd0; flush_i = 1'b0; out_rdy = 1'b1; rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        dv;
    logic [5:0]  ra, rb, rc, rt;
    logic        rfwr, wbv, wbwe;
    logic [5:0]  wbrt;
    logic [63:0] wbres;
    logic        fl, ordy, rstn;
    logic        e_rdy, e_v;
    logic [63:0] e_a, e_b;
    logic [31:0] e_st;
  } vec_t;

  function automatic vec_t mk(input int dv, ra, rb, rc, rt, rfwr,
                              input int wbv, wbwe, wbrt, input logic [63:0] wbres,
                              input int fl, ordy, rstn, e_rdy, e_v,
                              input logic [63:0] e_a, e_b, input int e_st);
    vec_t v;
    v.dv = 1'(dv); v.ra = 6'(ra); v.rb = 6'(rb); v.rc = 6'(rc); v.rt = 6'(rt);
    v.rfwr = 1'(rfwr); v.wbv = 1'(wbv); v.wbwe = 1'(wbwe); v.wbrt = 6'(wbrt);
    v.wbres = wbres; v.fl = 1'(fl); v.ordy = 1'(ordy); v.rstn = 1'(rstn);
    v.e_rdy = 1'(e_rdy); v.e_v = 1'(e_v); v.e_a = e_a; v.e_b = e_b; v.e_st = 32'(e_st);
    return v;
  endfunction

  vec_t tbl[$];
  int   pq[$];

  initial begin
    // dv ra rb rc rt rfwr | wbv we rt res | fl ordy rstn | rdy v a b stall
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,1,64'd10,     0,1,1, 1,0,64'd0,64'd0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,2,64'd20,     0,1,1, 1,0,64'd0,64'd0,0));
    tbl.push_back(mk(1,1,2,0,5,1, 0,0,0,64'd0,      0,1,1, 1,1,64'd10,64'd20,0));
    tbl.push_back(mk(1,5,0,0,6,1, 0,0,0,64'd0,      0,1,1, 0,0,64'd10,64'd20,1));
    tbl.push_back(mk(1,5,0,0,6,1, 0,0,0,64'd0,      0,1,1, 0,0,64'd10,64'd20,2));
    tbl.push_back(mk(1,5,0,0,6,1, 1,1,5,64'h1234,   0,1,1, 1,1,64'h1234,64'd0,2));
    tbl.push_back(mk(1,1,2,0,8,1, 0,0,0,64'd0,      0,0,1, 0,1,64'h1234,64'd0,3));
    tbl.push_back(mk(1,1,2,0,8,1, 0,0,0,64'd0,      0,0,1, 0,1,64'h1234,64'd0,4));
    tbl.push_back(mk(1,1,2,0,8,1, 0,0,0,64'd0,      0,0,1, 0,1,64'h1234,64'd0,5));
    tbl.push_back(mk(1,1,2,0,8,1, 0,0,0,64'd0,      0,1,1, 1,1,64'd10,64'd20,5));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,6,64'h66,     0,1,1, 1,0,64'd10,64'd20,5));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,8,64'h88,     0,1,1, 1,0,64'd10,64'd20,5));
    tbl.push_back(mk(1,0,0,0,7,1, 0,0,0,64'd0,      0,0,1, 1,1,64'd0,64'd0,5));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,64'd0,      1,0,1, 1,0,64'd0,64'd0,5));
    tbl.push_back(mk(1,7,0,0,0,0, 0,0,0,64'd0,      0,0,1, 1,1,64'h0100_0007,64'd0,5));
    tbl.push_back(mk(1,0,0,0,7,1, 0,0,0,64'd0,      1,0,1, 1,1,64'd0,64'd0,5));
    tbl.push_back(mk(1,0,7,0,0,0, 0,0,0,64'd0,      0,1,1, 0,0,64'd0,64'd0,6));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,7,64'h77,     0,1,1, 1,0,64'd0,64'd0,6));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,64'hFF,     0,1,1, 1,1,64'd0,64'd0,6));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,44,64'h4444,  0,1,1, 1,0,64'd0,64'd0,6));
    tbl.push_back(mk(1,0,44,0,0,1, 0,0,0,64'd0,     0,1,1, 1,1,64'd0,64'h4444,6));
    tbl.push_back(mk(1,0,0,0,9,0, 0,0,0,64'd0,      0,1,1, 1,1,64'd0,64'd0,6));
    tbl.push_back(mk(1,0,0,0,9,1, 0,0,0,64'd0,      0,1,1, 1,1,64'd0,64'd0,6));
    tbl.push_back(mk(1,0,0,0,9,1, 0,0,0,64'd0,      0,1,1, 0,0,64'd0,64'd0,7));
    tbl.push_back(mk(1,0,0,0,9,1, 1,0,9,64'h5555,   0,1,1, 1,1,64'd0,64'd0,7));
    tbl.push_back(mk(1,9,0,0,0,0, 0,0,0,64'd0,      0,1,1, 0,0,64'd0,64'd0,8));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,9,64'h99,     0,1,1, 1,0,64'd0,64'd0,8));
    tbl.push_back(mk(1,0,0,0,3,1, 0,0,0,64'd0,      0,0,1, 1,1,64'd0,64'd0,8));
    tbl.push_back(mk(1,3,0,0,0,0, 0,0,0,64'd0,      0,0,0, 0,0,64'd0,64'd0,0));
    tbl.push_back(mk(1,3,0,0,0,0, 0,0,0,64'd0,      0,1,1, 1,1,64'h0100_0003,64'd0,0));

    // Reset
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    chk("reset_out_v", {63'd0, out_v}, 64'd0);
    chk("reset_stall", {32'd0, stall_cnt}, 64'd0);

    // Preload every register with a known value
    for (int i = 1; i < 64; i++) begin
      idle_inputs();
      wb_v = 1'b1; wb_we = 1'b1; wb_Rt = 6'(i); wb_res = 64'h0100_0000 + 64'(i);
      step();
    end

    // Directed vector table
    foreach (tbl[k]) begin
      idle_inputs();
      dec_v = tbl[k].dv; dec_Ra = tbl[k].ra; dec_Rb = tbl[k].rb; dec_Rc = tbl[k].rc;
      dec_Rt = tbl[k].rt; dec_rfwr = tbl[k].rfwr; dec_ir = 64'hC0DE_0000 + 64'(k);
      wb_v = tbl[k].wbv; wb_we = tbl[k].wbwe; wb_Rt = tbl[k].wbrt; wb_res = tbl[k].wbres;
      flush_i = tbl[k].fl; out_rdy = tbl[k].ordy; rst_ni = tbl[k].rstn;
      step();
      chk($sformatf("tbl%0d_rdy", k),   {63'd0, rdy_seen}, {63'd0, tbl[k].e_rdy});
      chk($sformatf("tbl%0d_v", k),     {63'd0, out_v},    {63'd0, tbl[k].e_v});
      chk($sformatf("tbl%0d_a", k),     out_a,             tbl[k].e_a);
      chk($sformatf("tbl%0d_b", k),     out_b,             tbl[k].e_b);
      chk($sformatf("tbl%0d_stall", k), {32'd0, stall_cnt}, {32'd0, tbl[k].e_st});
    end

    // Hand-written: reset in the middle of a RAW stall
    idle_inputs();
    dec_v = 1'b1; dec_Rt = 6'd12; dec_rfwr = 1'b1; dec_ir = 64'hAAAA;
    step();
    chk("seq_issue_rdy", {63'd0, rdy_seen}, 64'd1);
    idle_inputs();
    dec_v = 1'b1; dec_Ra = 6'd12; out_rdy = 1'b0;
    step();
    chk("seq_raw_rdy", {63'd0, rdy_seen}, 64'd0);
    chk("seq_raw_stall", {32'd0, stall_cnt}, 64'd1);
    rst_ni = 1'b0;
    step();
    chk("seq_rst_rdy", {63'd0, rdy_seen}, 64'd0);
    chk("seq_rst_v", {63'd0, out_v}, 64'd0);
    chk("seq_rst_stall", {32'd0, stall_cnt}, 64'd0);
    rst_ni = 1'b1; out_rdy = 1'b1;
    step();
    chk("seq_post_rdy", {63'd0, rdy_seen}, 64'd1);
    chk("seq_post_v", {63'd0, out_v}, 64'd1);
    chk("seq_post_a", out_a, 64'h0100_000C);

    // Randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      idle_inputs();
      dec_v    = ($urandom_range(0, 3) != 0);
      dec_Ra   = 6'($urandom_range(0, 15));
      dec_Rb   = 6'($urandom_range(0, 15));
      dec_Rc   = 6'($urandom_range(0, 15));
      dec_Rt   = 6'($urandom_range(0, 15));
      dec_rfwr = 1'($urandom_range(0, 1));
      dec_ir   = {$urandom, $urandom};
      wb_v     = ($urandom_range(0, 4) < 2);
      wb_we    = ($urandom_range(0, 4) != 0);
      pq.delete();
      for (int i = 1; i < 64; i++) if (m_pend[i]) pq.push_back(i);
      if (pq.size() > 0 && $urandom_range(0, 3) != 0)
        wb_Rt = 6'(pq[$urandom_range(0, pq.size() - 1)]);
      else
        wb_Rt = 6'($urandom_range(0, 63));
      wb_res   = {$urandom, $urandom};
      flush_i  = ($urandom_range(0, 9) == 0);
      out_rdy  = ($urandom_range(0, 9) < 7);
      rst_ni   = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/thor2022_regfetch.md
Name: thor2022_regfetch

Overview:
- Register-fetch stage sitting directly downstream of the register-select decoders (Ra/Rb/Rc/Rt, stack-pointer aliases already resolved to 44..47).
- Holds the 64-entry general register file and a per-register pending-write scoreboard.
- Stalls decode on RAW/WAW hazards, forwards the writeback result, and presents registered operands to execute over a valid/ready handshake.

Parameters:
- WID, 64, operand/register width in bits
- NREGS, 64, number of architectural registers; index width is 6
- CNTW, 32, width of the saturating stall counter

Ports:
- clk_i  in  1  stage clock
- rst_ni  in  1  synchronous reset, active-low
- dec_v  in  1  decode presents a valid instruction
- dec_rdy  out  1  stage accepts the decode instruction this cycle
- dec_Ra  in  6  source A index
- dec_Rb  in  6  source B index
- dec_Rc  in  6  source C index
- dec_Rt  in  6  destination index
- dec_rfwr  in  1  instruction writes dec_Rt
- dec_ir  in  64  instruction word, passed through
- wb_v  in  1  writeback retires an instruction that holds a pending bit
- wb_we  in  1  writeback actually writes the register file
- wb_Rt  in  6  writeback destination
- wb_res  in  WID  writeback data
- flush_i  in  1  discard the instruction held in the output register
- out_v  out  1  operands valid to execute
- out_rdy  in  1  execute accepts the output
- out_a, out_b, out_c  out  WID  operand values
- out_Rt  out  6  destination
- out_rfwr  out  1  destination write flag
- out_ir  out  64  instruction word
- stall_cnt  out  CNTW  cycles with dec_v=1 and dec_rdy=0, saturating

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - Clears out_v, out_rfwr, out_Rt, out_a/b/c, out_ir, stall_cnt and all pending bits.
  - Register file contents are not reset.
  - dec_rdy is 0 while rst_ni=0.
  - Reset mid-stall or mid-handshake discards everything.
- Register 0:
  - Reads always return 0.
  - Writes to 0 are ignored.
  - dec_rfwr with dec_Rt=0 sets no pending bit.
- Source hazard: source X is hazardous when pend[X]=1, X!=0, and NOT (wb_v & wb_we & wb_Rt==X).
- WAW hazard: dec_rfwr & dec_Rt!=0 & pend[dec_Rt] & NOT (wb_v & wb_Rt==dec_Rt).
- dec_rdy = rst_ni & no hazard on Ra/Rb/Rc & no WAW & (!out_v | out_rdy | flush_i).
- Issue: dec_v & dec_rdy.
  - On the next edge the output register loads operands, Rt, rfwr and ir, and out_v becomes 1.
  - Latency is 1 cycle from issue to out_v.
  - Otherwise, if out_v & out_rdy, out_v becomes 0.
  - Otherwise the output holds stable; no output changes while out_v=1 and out_rdy=0.
- Operand read is combinational from the register file with priority: r0 → 0; writeback match (wb_v & wb_we & wb_Rt==X) → wb_res; else file value.
- Writeback: when wb_v & wb_we & wb_Rt!=0, the file is written at the edge.
- Pending bits, per edge, in priority order:
  - Cleared for wb_Rt when wb_v.
  - Set for dec_Rt on issue with dec_rfwr & dec_Rt!=0.
  - Simultaneous clear and set of the same index: set wins. This is only reachable for a WAW that is resolved by that same writeback.
- Flush: flush_i forces out_v to 0 at the next edge unless a new issue occurs in the same cycle, in which case the new instruction loads.
  - The held instruction, if out_v=1 and out_rfwr=1, has its pending bit cleared, unless the same index is set by a simultaneous issue.
  - Instructions already accepted by execute are not affected and must still retire via wb_v.
- A hold (out_v=1, out_rdy=0) with no flush blocks issue but does not block writeback.
- stall_cnt increments when dec_v & !dec_rdy & rst_ni, and saturates at all-ones.
- Single writeback port only; a second writer is out of scope.

Test Plan:
1. Independent stream: reset, then issue add Rt=5 (Ra=1, Rb=2), with r1=10 and r2=20 preloaded via wb → out_v one cycle after issue with out_a=10, out_b=20; pend[5]=1; dec_rdy stays 1.
2. RAW stall plus forward: issue Rt=5, then Ra=5 while pend[5]=1 → dec_rdy=0 and stall_cnt counts each cycle. Assert wb_v/wb_we, wb_Rt=5, wb_res=0x1234 → dec_rdy=1 in that same cycle, out_a=0x1234 next cycle, pend[5]=0.
3. Backpressure: out_rdy=0 for 3 cycles with dec_v=1 → out_* stable and dec_rdy=0 for those 3 cycles; stall_cnt +3; release → the next instruction loads one cycle later.
4. Flush: held instruction with Rt=7 and out_rdy=0, assert flush_i → out_v=0 and pend[7]=0 after one edge. Also flush concurrent with an issue of Rt=7 → out_v=1 and pend[7]=1.
5. Register 0 and aliases: wb to Rt=0 with 0xFF → a read of Ra=0 gives 0. Write Rt=44 via wb then read Rb=44 → correct value; issue with dec_Rt=0 and rfwr=1 → no stall for a later Ra=0.
6. Reset mid-operation: pend[3]=1 and out_v=1, pull rst_ni low for 1 cycle → out_v=0, all pending cleared, stall_cnt=0; an instruction reading r3 issues with no stall.
